pipeline_sequencer: RTL

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

---
 rtl/pipeline_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: central stall/flush/enable controller for a 5-stage
// in-order pipeline. A registered state (RUN, BUBBLE, MEM_WAIT, HALTED) plus
// the current hazard inputs produce all stage-register enables, bubble
// injections and the PC mux select in the same cycle.
// Optional build macro PIPE_PERF_CNT_EN adds saturating performance counters
// (stall_cycles, flush_count, mem_wait_cycles) of width CNT_WIDTH.
`timescale 1ns/1ps
module pipeline_sequencer #(
    parameter int CNT_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic EX_stall,
    input  logic EX_branch_taken,
    input  logic MEM_busy,
    input  logic halt_req,
    output logic PC_write,
    output logic IF_ID_write,
    output logic ID_EX_write,
    output logic EX_MEM_write,
    output logic MEM_WB_write,
    output logic IF_ID_flush,
    output logic ID_EX_flush,
    output logic EX_MEM_flush,
    output logic MEM_WB_flush,
    output logic PC_sel,
    output logic halted,
    output logic stall_error
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count,
    output logic [CNT_WIDTH-1:0] mem_wait_cycles
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BUBBLE   = 2'd1,
        MEM_WAIT = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   stall_error_reg;
    logic   stall_error_set;

    // State register: reset always lands in RUN, wherever the pipeline was.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and all control outputs, resolved in priority order:
    // reset, halted, halt request, memory busy, load-use stall, branch, normal.
    always_comb begin
        state_next      = state_reg;
        PC_write        = 1'b1;
        IF_ID_write     = 1'b1;
        ID_EX_write     = 1'b1;
        EX_MEM_write    = 1'b1;
        MEM_WB_write    = 1'b1;
        IF_ID_flush     = 1'b0;
        ID_EX_flush     = 1'b0;
        EX_MEM_flush    = 1'b0;
        MEM_WB_flush    = 1'b0;
        PC_sel          = 1'b0;
        halted          = 1'b0;
        stall_error_set = 1'b0;

        if (rst) begin
            // Hold every stage and load bubbles everywhere while in reset.
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_write = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
            MEM_WB_flush = 1'b1;
            state_next   = RUN;
        end else if (state_reg == HALTED) begin
            // Frozen until reset; every hazard input is ignored.
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_write = 1'b0;
            halted       = 1'b1;
        end else if (halt_req) begin
            // Halt has reached WB: stop everything now, nothing younger retires.
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_write = 1'b0;
            state_next   = HALTED;
        end else if (MEM_busy) begin
            // Freeze IF..MEM (a pending branch stays in EX); WB takes a bubble
            // so the instruction already written back is not retired twice.
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_write = 1'b0;
            MEM_WB_flush = 1'b1;
            state_next   = MEM_WAIT;
        end else if (EX_stall && (state_reg != BUBBLE)) begin
            // Load-use: hold the front end, push a bubble into MEM. Any branch
            // seen this cycle is re-presented once the stall clears.
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_write  = 1'b0;
            EX_MEM_flush = 1'b1;
            state_next   = BUBBLE;
        end else begin
            // A stall right after a bubble means the hazard checker is broken:
            // flag it and keep the pipeline moving.
            if (EX_stall) begin
                stall_error_set = 1'b1;
            end
            if (EX_branch_taken) begin
                PC_sel      = 1'b1;
                IF_ID_flush = 1'b1;
                ID_EX_flush = 1'b1;
            end
            state_next = RUN;
        end
    end

    // Sticky hazard-checker error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_error_reg <= 1'b0;
        end else if (stall_error_set) begin
            stall_error_reg <= 1'b1;
        end
    end

    assign stall_error = stall_error_reg;

`ifdef PIPE_PERF_CNT_EN
    // Counter events are decoded from the outputs: EX_MEM_flush outside reset
    // only occurs on a load-use stall, MEM_WB_flush outside reset only on a
    // memory wait, and PC_sel only on a taken branch. None fire in HALTED.
    logic [2:0]           cnt_inc;
    logic [CNT_WIDTH-1:0] cnt_reg [3];

    assign cnt_inc[0] = EX_MEM_flush & ~rst;
    assign cnt_inc[1] = PC_sel;
    assign cnt_inc[2] = MEM_WB_flush & ~rst;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            // Saturating event counter.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_WIDTH{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    endgenerate

    assign stall_cycles    = cnt_reg[0];
    assign flush_count     = cnt_reg[1];
    assign mem_wait_cycles = cnt_reg[2];
`else
    // Counter width only matters when the counters are built.
    generate
        if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        end
    endgenerate
`endif

endmodule
